seq_gen_tx: RTL and testbench

- Serial sequence transmitter on the switch-word path. It latches an 8-bit word from the DIP switches (bm) on a start request and shifts it out MSB-first.
- Each bit is held for a programmable bit period, with a per-bit valid strobe.
- It generates test sequences for the on-board sequence-detection course.
- A receiving shift register rebuilds the parallel word that the pattern detector consumes.

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_gen_tx_if.sv | 31 +++
 rtl/bit_tick_gen.sv | 40 ++++
 rtl/seq_gen_tx.sv | 115 +++++++++++
 tb/tb_seq_gen_tx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the sequence transmitter, its bus
// interface and the test benches.
//   state_t        - transmitter FSM states (binary encoded)
//   DATA_W_DEFAULT - default transmitted word width (DIP switch width)
//   BIT_DIV_SIM    - short bit period used in simulation
package seq_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned BIT_DIV_SIM    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_gen_tx_if.sv
// seq_gen_tx_if: control and serial-output bundle of the sequence
// transmitter.
//   start, repeat_en, bm                             - driven by the controller (master)
//   ser_out, ser_valid, bit_idx, busy, done           - driven by the transmitter (slave)
interface seq_gen_tx_if
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
);
    localparam int unsigned IDX_W = $clog2(DATA_W);

    logic              start;
    logic              repeat_en;
    logic [DATA_W-1:0] bm;
    logic              ser_out;
    logic              ser_valid;
    logic [IDX_W-1:0]  bit_idx;
    logic              busy;
    logic              done;

    modport master (
        output start, repeat_en, bm,
        input  ser_out, ser_valid, bit_idx, busy, done
    );

    modport slave (
        input  start, repeat_en, bm,
        output ser_out, ser_valid, bit_idx, busy, done
    );

endinterface

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: bit-period counter. Counts clk cycles while en is high and
// raises tick on the last cycle of each BIT_DIV-cycle period, then wraps.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - count enable
//   clr        - synchronous clear, overrides counting
//   tick       - high during the final cycle of the period (decoded from the
//                registered count, so no path from en/clr timing into the count)
module bit_tick_gen #(
    parameter int unsigned BIT_DIV = 4,
    parameter int unsigned CNT_W   = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_gen_tx.sv
// seq_gen_tx: serial sequence transmitter. On a start request it latches
// the switch word bm and shifts it out MSB-first, holding each bit for
// BIT_DIV clocks with a ser_valid strobe on the last cycle of each bit.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - seq_gen_tx_if.slave: start/repeat_en/bm in,
//                ser_out/ser_valid/bit_idx/busy/done out
module seq_gen_tx
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned BIT_DIV = 25_000_000,
    parameter int unsigned CNT_W   = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_gen_tx_if.slave  bus
);
    localparam int unsigned      IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ser_out_q, ser_out_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              launch;
    logic              tick;

    bit_tick_gen #(
        .BIT_DIV (BIT_DIV),
        .CNT_W   (CNT_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_SHIFT),
        .clr   (launch),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        ser_out_d = ser_out_q;
        bit_idx_d = bit_idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        launch    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                launch = bus.start;
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        shreg_d   = shreg_q << 1;
                        ser_out_d = shreg_d[DATA_W-1];
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                // bit_idx returns to 0 so IDLE shows reset values; ser_out keeps the last bit
                bit_idx_d = '0;
                if (bus.repeat_en) begin
                    launch = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Launch is shared by IDLE+start and DONE+repeat_en
        if (launch) begin
            shreg_d   = bus.bm;
            ser_out_d = bus.bm[DATA_W-1];
            bit_idx_d = '0;
            busy_d    = 1'b1;
            state_d   = ST_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            ser_out_q <= 1'b0;
            bit_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            ser_out_q <= ser_out_d;
            bit_idx_q <= bit_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = tick;
    assign bus.bit_idx   = bit_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_gen_tx.sv
// tb_seq_gen_tx: directed bench for seq_gen_tx. Instance a uses a 4-cycle
// bit period, instance b a 1-cycle bit period.
module tb_seq_gen_tx;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    seq_gen_tx_if #(.DATA_W(8)) a_if ();
    seq_gen_tx_if #(.DATA_W(8)) b_if ();

    seq_gen_tx #(.DATA_W(8), .BIT_DIV(BIT_DIV_SIM), .CNT_W(26)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    seq_gen_tx #(.DATA_W(8), .BIT_DIV(1), .CNT_W(26)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    typedef struct {
        logic       start;
        logic [7:0] bm;
        logic       so;
        logic       sv;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vt[37];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic launch_a(input logic [7:0] w, input logic rep);
        @(negedge clk);
        a_if.bm        = w;
        a_if.repeat_en = rep;
        a_if.start     = 1'b1;
        @(negedge clk);
        a_if.start = 1'b0;
    endtask

    // Collects one frame from instance a, starting with the current cycle;
    // returns just after the last strobe (the DONE cycle).
    task automatic rx_frame(output logic [7:0] word, output int det, output int busy_low);
        int         n = 0;
        int         cyc = 0;
        logic [2:0] hist = '0;
        word = '0;
        det = 0;
        busy_low = 0;
        while (n < 8 && cyc < 200) begin
            if (a_if.busy !== 1'b1) busy_low++;
            if (a_if.ser_valid === 1'b1) begin
                word = {word[6:0], a_if.ser_out};
                hist = {hist[1:0], a_if.ser_out};
                n++;
                if (n >= 3 && hist == 3'b101) det++;
            end
            @(negedge clk);
            cyc++;
        end
        check("rx_bits", n, 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", failed);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wb2;
        logic [7:0] wa5;
        logic [7:0] wc3;
        logic [7:0] w;
        int         det;
        int         bl;
        int         cyc;
        int         dcnt;

        wb2 = 8'hB2;
        wa5 = 8'hA5;
        wc3 = 8'hC3;

        // Frame of 0xB2 with a start at row 10 and bm=FF from row 12 on
        for (int k = 1; k <= 37; k++) begin
            vt[k-1].start = (k == 10);
            vt[k-1].bm    = (k >= 12) ? 8'hFF : 8'hB2;
            if (k <= 32) begin
                vt[k-1].so   = wb2[7 - (k - 1) / 4];
                vt[k-1].sv   = (k % 4 == 0);
                vt[k-1].idx  = 3'((k - 1) / 4);
                vt[k-1].busy = 1'b1;
                vt[k-1].done = 1'b0;
            end else if (k == 33) begin
                vt[k-1].so   = 1'b0;
                vt[k-1].sv   = 1'b0;
                vt[k-1].idx  = 3'd7;
                vt[k-1].busy = 1'b1;
                vt[k-1].done = 1'b1;
            end else begin
                vt[k-1].so   = 1'b0;
                vt[k-1].sv   = 1'b0;
                vt[k-1].idx  = 3'd0;
                vt[k-1].busy = 1'b0;
                vt[k-1].done = 1'b0;
            end
        end

        a_if.start = 1'b0; a_if.repeat_en = 1'b0; a_if.bm = '0;
        b_if.start = 1'b0; b_if.repeat_en = 1'b0; b_if.bm = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ser_out",   a_if.ser_out,   0);
        check("rst_ser_valid", a_if.ser_valid, 0);
        check("rst_bit_idx",   a_if.bit_idx,   0);
        check("rst_busy",      a_if.busy,      0);
        check("rst_done",      a_if.done,      0);
        check("rst_b_valid",   b_if.ser_valid, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", a_if.busy, 0);

        // Table-driven frame: cycle N+1 .. N+37
        launch_a(8'hB2, 1'b0);
        for (int i = 0; i < 37; i++) begin
            check($sformatf("t%0d_ser_out", i + 1),   a_if.ser_out,   vt[i].so);
            check($sformatf("t%0d_ser_valid", i + 1), a_if.ser_valid, vt[i].sv);
            check($sformatf("t%0d_bit_idx", i + 1),   a_if.bit_idx,   vt[i].idx);
            check($sformatf("t%0d_busy", i + 1),      a_if.busy,      vt[i].busy);
            check($sformatf("t%0d_done", i + 1),      a_if.done,      vt[i].done);
            a_if.start = vt[i].start;
            a_if.bm    = vt[i].bm;
            @(negedge clk);
        end
        a_if.start = 1'b0;

        // Repeat mode: bm changes to C3 during frame 1
        launch_a(8'h5A, 1'b1);
        a_if.bm = 8'hC3;
        rx_frame(w, det, bl);
        check("rep_frame1", w, 8'h5A);
        check("rep_busy_low1", bl, 0);
        check("rep_done_gap", a_if.done, 1);
        check("rep_busy_gap", a_if.busy, 1);
        @(negedge clk);
        a_if.repeat_en = 1'b0;
        check("rep_f2_first_bit", a_if.ser_out, wc3[7]);
        check("rep_f2_idx0", a_if.bit_idx, 0);
        check("rep_f2_busy", a_if.busy, 1);
        rx_frame(w, det, bl);
        check("rep_frame2", w, 8'hC3);
        check("rep_busy_low2", bl, 0);
        check("rep_done2", a_if.done, 1);
        @(negedge clk);
        check("rep_end_busy", a_if.busy, 0);
        check("rep_end_done", a_if.done, 0);

        // Asynchronous reset in the middle of bit 3
        launch_a(8'hB2, 1'b0);
        cyc = 0;
        while (a_if.bit_idx !== 3'd3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach_idx3", a_if.bit_idx, 3);
        check("mid_pre_ser_out", a_if.ser_out, wb2[4]);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ser_out",   a_if.ser_out,   0);
        check("mid_rst_ser_valid", a_if.ser_valid, 0);
        check("mid_rst_bit_idx",   a_if.bit_idx,   0);
        check("mid_rst_busy",      a_if.busy,      0);
        check("mid_rst_done",      a_if.done,      0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_if.done !== 1'b0 || a_if.busy !== 1'b0) dcnt++;
        end
        check("mid_no_activity", dcnt, 0);
        launch_a(8'h3C, 1'b0);
        rx_frame(w, det, bl);
        check("mid_new_frame", w, 8'h3C);
        check("mid_new_done", a_if.done, 1);
        @(negedge clk);

        // Loopback into a receiver and a 101 detector
        launch_a(8'hAA, 1'b0);
        rx_frame(w, det, bl);
        check("loop_word", w, 8'hAA);
        check("loop_det101", det, 3);
        check("loop_done", a_if.done, 1);
        @(negedge clk);

        // One bit per clock on instance b
        @(negedge clk);
        b_if.bm    = 8'hA5;
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("div1_valid%0d", k), b_if.ser_valid, 1);
            check($sformatf("div1_bit%0d", k),   b_if.ser_out,   wa5[7 - k]);
            check($sformatf("div1_idx%0d", k),   b_if.bit_idx,   k);
            @(negedge clk);
        end
        check("div1_done",       b_if.done,      1);
        check("div1_done_valid", b_if.ser_valid, 0);
        @(negedge clk);
        check("div1_end_busy", b_if.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
